// File: rtl/soc_led_pkg.sv
// rtl/soc_led_pkg.sv - shared register map and helpers for the LED PWM dimmer
//
// Purpose: register word addresses, CTRL bit positions, the readback
// position of the blink phase, reset value of CTRL, and the PWM gate
// function shared by the dimmer.
// Ports: none (package).
package soc_led_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_DUTY     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_BLINK    = 2'd3;

  // CTRL register layout
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam logic [1:0] CTRL_RESET = 2'b01;

  // Bit of the BLINK readback word that carries the live blink phase
  localparam int PHASE_BIT = 31;

  // Full-scale duty forces the gate on so 8'hFF means 100%, not 255/256.
  function automatic logic pwm_gate(input logic [7:0] cnt, input logic [7:0] duty);
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// rtl/led_pwm_timebase.sv - prescaler and 8-bit PWM counter for the LED dimmer
//
// Purpose: divides clk by (prescale+1) into a one-cycle tick and counts
// ticks in an 8-bit PWM counter; the tick that wraps 255->0 is period_end.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   enable           - 0 holds both counters at zero
//   prescale         - terminal count of the prescaler
//   clr_prescale     - register write to PRESCALE; clears the prescaler
//   pwm_cnt          - current PWM counter value
//   tick             - prescaler terminal count reached this cycle
//   period_end       - tick while pwm_cnt is 255
module led_pwm_timebase (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] prescale,
  input  logic        clr_prescale,
  output logic [7:0]  pwm_cnt,
  output logic        tick,
  output logic        period_end
);

  logic [15:0] presc_cnt;

  assign tick       = enable && (presc_cnt == prescale);
  assign period_end = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= 16'd0;
      pwm_cnt   <= 8'd0;
    end else if (!enable) begin
      presc_cnt <= 16'd0;
      pwm_cnt   <= 8'd0;
    end else begin
      // A PRESCALE write and a tick both land on zero; the PWM counter
      // still advances on the tick even when the write coincides.
      if (clr_prescale || tick) begin
        presc_cnt <= 16'd0;
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// rtl/led_pwm_dimmer.sv - Avalon-MM controlled PWM dimmer and blinker for board LEDs
//
// Purpose: sits between the Green_LEDs PIO and the LED pins; gates the
// pattern with a PWM duty cycle and an optional slow blink.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   address          - register word address (CTRL, DUTY, PRESCALE, BLINK)
//   chipselect       - slave select
//   write_n          - active-low write strobe
//   writedata        - write data
//   readdata         - combinational read data, zero wait states
//   led_in           - LED pattern from the PIO
//   led_out          - gated pattern to the LED pins, active-high
module led_pwm_dimmer
  import soc_led_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_DUTY     = 8'hFF,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd0,
  parameter logic [15:0] DEFAULT_BLINK    = 16'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  logic [1:0]  ctrl;
  logic [7:0]  duty;
  logic [15:0] prescale;
  logic [15:0] blink;
  logic [15:0] blink_cnt;
  logic        phase;
  logic [7:0]  in_q;

  logic        wr_en;
  logic        wr_prescale;
  logic        wr_blink;
  logic        enable;
  logic        blink_en;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        period_end;
  logic        gate;
  logic        unused_wdata;

  assign wr_en       = chipselect && !write_n;
  assign wr_prescale = wr_en && (address == ADDR_PRESCALE);
  assign wr_blink    = wr_en && (address == ADDR_BLINK);
  assign enable      = ctrl[CTRL_ENABLE_BIT];
  assign blink_en    = ctrl[CTRL_BLINK_EN_BIT];
  assign unused_wdata = ^writedata[31:16];

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= CTRL_RESET;
      duty     <= DEFAULT_DUTY;
      prescale <= DEFAULT_PRESCALE;
      blink    <= DEFAULT_BLINK;
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL:     ctrl     <= writedata[1:0];
        ADDR_DUTY:     duty     <= writedata[7:0];
        ADDR_PRESCALE: prescale <= writedata[15:0];
        ADDR_BLINK:    blink    <= writedata[15:0];
        default:       ;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata[1:0]  = ctrl;
      ADDR_DUTY:     readdata[7:0]  = duty;
      ADDR_PRESCALE: readdata[15:0] = prescale;
      ADDR_BLINK: begin
        readdata[15:0]      = blink;
        readdata[PHASE_BIT] = phase;
      end
      default:       readdata = 32'd0;
    endcase
  end

  led_pwm_timebase u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .prescale     (prescale),
    .clr_prescale (wr_prescale),
    .pwm_cnt      (pwm_cnt),
    .tick         (tick),
    .period_end   (period_end)
  );

  // Blink: phase toggles once every (blink+1) PWM periods. Phase rests
  // at 1 (LEDs visible) whenever blinking or the block is off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= 16'd0;
      phase     <= 1'b1;
    end else if (!enable || !blink_en) begin
      blink_cnt <= 16'd0;
      phase     <= 1'b1;
    end else if (wr_blink) begin
      // Restart the count against the new BLINK value; phase keeps going.
      blink_cnt <= 16'd0;
    end else if (period_end) begin
      if (blink_cnt == blink) begin
        phase     <= ~phase;
        blink_cnt <= 16'd0;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  assign gate = pwm_gate(pwm_cnt, duty);

  // Two-stage path: led_in is captured once, then gated into led_out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= 8'd0;
      led_out <= 8'd0;
    end else begin
      in_q    <= led_in;
      led_out <= in_q & {8{gate & phase & enable}};
    end
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// tb/tb_led_pwm_dimmer.sv - directed self-checking bench for led_pwm_dimmer
module tb_led_pwm_dimmer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_in;
  logic [7:0]  led_out;

  int checks   = 0;
  int failures = 0;
  int cnt;
  logic [7:0] s_first;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       s_ph;

  always #5 clk = ~clk;

  led_pwm_dimmer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    led_in     = 8'hA5;
    step(3);

    // Reset state
    chk("reset_led_out", {24'd0, led_out}, 32'h0);
    rd_chk("reset_ctrl", 2'd0, 32'h1);
    rd_chk("reset_duty", 2'd1, 32'hFF);
    rd_chk("reset_blink_phase", 2'd3, 32'h8000_0000);

    // Defaults pass led_in through after two edges
    reset_n = 1'b1;
    step(1);
    chk("default_edge1", {24'd0, led_out}, 32'h0);
    step(1);
    chk("default_edge2", {24'd0, led_out}, 32'hA5);

    // Disable: led_out drops on the edge after the write
    wr(2'd0, 32'h0);
    chk("disable_write_edge", {24'd0, led_out}, 32'hA5);
    step(1);
    chk("disable_next_edge", {24'd0, led_out}, 32'h0);

    // Dimming at 0x40/256 from a freshly enabled period
    led_in = 8'hFF;
    wr(2'd1, 32'h40);
    wr(2'd0, 32'h1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (i == 0)  s_first = led_out;
      if (i == 63) s_a = led_out;
      if (i == 64) s_b = led_out;
      if (led_out == 8'hFF) cnt++;
    end
    chk("dim_first", {24'd0, s_first}, 32'hFF);
    chk("dim_cycle64", {24'd0, s_a}, 32'hFF);
    chk("dim_cycle65", {24'd0, s_b}, 32'h0);
    chk("dim_high_count", cnt, 32'd64);
    rd_chk("dim_duty_readback", 2'd1, 32'h40);

    // DUTY=0: permanently off
    wr(2'd1, 32'h0);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (led_out != 8'h00) cnt++;
    end
    chk("duty0_nonzero_count", cnt, 32'd0);

    // DUTY=FF: never drops
    wr(2'd1, 32'hFF);
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      step(1);
      if (led_out != 8'hFF) cnt++;
    end
    chk("dutyff_drop_count", cnt, 32'd0);

    // PRESCALE=2, DUTY=1: only pwm_cnt 0 lights, which lasts 3 cycles
    wr(2'd2, 32'h2);
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h1);
    cnt = 0;
    for (int i = 0; i < 768; i++) begin
      step(1);
      if (i == 2) s_a = led_out;
      if (i == 3) s_b = led_out;
      if (led_out == 8'hFF) cnt++;
    end
    chk("presc_third_cycle", {24'd0, s_a}, 32'hFF);
    chk("presc_fourth_cycle", {24'd0, s_b}, 32'h0);
    chk("presc_high_count", cnt, 32'd3);
    rd_chk("presc_readback", 2'd2, 32'h2);

    // Blink: BLINK=1 toggles phase every 512 cycles at PRESCALE=0
    wr(2'd2, 32'h0);
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h3);
    address = 2'd3;
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      step(1);
      if (i == 510) s_ph = readdata[31];
      if (led_out == 8'hFF) cnt++;
    end
    chk("blink_on_count", cnt, 32'd512);
    chk("blink_phase_before_toggle", {31'd0, s_ph}, 32'h1);
    chk("blink_phase_after_toggle", {31'd0, readdata[31]}, 32'h0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (led_out == 8'h00) cnt++;
    end
    chk("blink_off_count", cnt, 32'd200);
    chk("blink_off_readback", readdata, 32'h0000_0001);

    // Asynchronous reset in the blink-off phase
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_led_out", {24'd0, led_out}, 32'h0);
    chk("async_rst_phase_blink", readdata, 32'h8000_0000);
    rd_chk("async_rst_ctrl", 2'd0, 32'h1);
    rd_chk("async_rst_duty", 2'd1, 32'hFF);
    rd_chk("async_rst_prescale", 2'd2, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("after_rst_passthrough", {24'd0, led_out}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
